// File: rtl/ga_grid_pkg.sv
// ga_grid_pkg: shared states and sizing constants for the grid evaluation sequencer
package ga_grid_pkg;
  localparam int GRID_DEPTH = 256;
  localparam int LOGIC_IN_W = 3;
  localparam int LOGIC_OUT_W = 3;
  localparam int NUM_VECTORS = 8;
  localparam int FITNESS_W = 5;
  typedef enum logic [2:0] {IDLE, LOAD, APPLY, SAMPLE, DONE} state_t;
endpackage

// File: rtl/bit_match_count.sv
// bit_match_count: number of equal bit positions between two grid output words
module bit_match_count
  import ga_grid_pkg::*;
(
  input  logic [LOGIC_OUT_W-1:0] a,
  input  logic [LOGIC_OUT_W-1:0] b,
  output logic [1:0]             count
);
  logic [LOGIC_OUT_W-1:0] eq;
  assign eq = ~(a ^ b);
  assign count = 2'(eq[0]) + 2'(eq[1]) + 2'(eq[2]);
endmodule

// File: rtl/grid_eval_sequencer.sv
// grid_eval_sequencer: loads a circuit into the grid RAM, sweeps all input vectors and scores the responses
module grid_eval_sequencer
  import ga_grid_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEPTH = GRID_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [23:0]            target,
  input  logic                   cfg_valid,
  input  logic [7:0]             cfg_data,
  output logic                   cfg_ready,
  output logic [7:0]             ram_address,
  output logic [7:0]             ram_data,
  output logic                   ram_wren,
  output logic                   grid_wren,
  output logic [LOGIC_IN_W-1:0]  login,
  input  logic [LOGIC_OUT_W-1:0] logout,
  output logic                   busy,
  output logic                   done,
  output logic [FITNESS_W-1:0]   fitness
);
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
  localparam logic [LOGIC_IN_W-1:0] LAST_VEC = LOGIC_IN_W'(NUM_VECTORS - 1);
  state_t state, state_n;
  logic [7:0] addr;
  logic [LOGIC_IN_W-1:0] vec, login_q;
  logic [3:0] settle;
  logic [FITNESS_W-1:0] acc, fit_q;
  logic [23:0] tgt;
  logic [1:0] match;
  logic wr;
  bit_match_count u_match (.a(logout), .b(tgt[3*vec +: 3]), .count(match));
  assign wr = (state == LOAD) && cfg_valid;
  assign cfg_ready = state == LOAD;
  assign grid_wren = state == LOAD;
  assign ram_wren = wr;
  assign ram_address = addr;
  assign ram_data = wr ? cfg_data : 8'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign login = (state == APPLY || state == SAMPLE) ? vec : login_q;
  assign fitness = done ? acc : fit_q;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (wr && addr == LAST_ADDR) ? APPLY : LOAD;
      APPLY:   state_n = (settle == LAST_SETTLE) ? SAMPLE : APPLY;
      SAMPLE:  state_n = (vec == LAST_VEC) ? DONE : APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      vec <= '0;
      settle <= '0;
      acc <= '0;
      fit_q <= '0;
      tgt <= '0;
      login_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        tgt <= target;
        addr <= '0;
        vec <= '0;
        acc <= '0;
      end
      if (wr) addr <= (addr == LAST_ADDR) ? 8'd0 : addr + 8'd1;
      settle <= (state == APPLY && state_n == APPLY) ? settle + 4'd1 : 4'd0;
      if (state == SAMPLE) begin
        acc <= acc + FITNESS_W'(match);
        vec <= vec + 1'b1;
        login_q <= vec;
      end
      if (state == DONE) fit_q <= acc;
    end
  end
endmodule

// File: tb/tb_grid_eval_sequencer.sv
// tb_grid_eval_sequencer: directed checks of load, sweep, scoring, backpressure and reset behaviour
module tb_grid_eval_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [23:0] target = 24'hFAC688;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic cfg_ready, ram_wren, grid_wren, busy, done;
  logic [7:0] ram_address, ram_data;
  logic [2:0] login, logout;
  logic [4:0] fitness;
  int mode = 0;
  int total = 0;
  int bad = 0;
  grid_eval_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .target(target),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .grid_wren(grid_wren), .login(login), .logout(logout),
    .busy(busy), .done(done), .fitness(fitness)
  );
  assign logout = (mode == 0) ? login : (mode == 1) ? ~login : 3'b000;
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_reset_vals();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_grid_wren", grid_wren, 0);
    check("rst_login", login, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fitness", fitness, 0);
  endtask
  task automatic run_eval(input int m, input bit gaps, input bit poke,
                          input int exp_fit, input int exp_lat, input int prev_fit);
    int wr = 0;
    int bad_wr = 0;
    int dn = 0;
    int dcyc = -1;
    int fit_at_done = -1;
    mode = m;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 2000 && (dcyc < 0 || k < dcyc + 5); k++) begin
      cfg_valid = gaps ? (k % 2 == 0) : 1'b1;
      cfg_data = 8'(wr);
      start = poke && k == 270;
      @(negedge clock);
      if (k == 1) check("fit_hold", fitness, prev_fit);
      if (ram_wren) begin
        if (ram_address != 8'(wr) || ram_data != 8'(wr) || !cfg_valid) bad_wr++;
        wr++;
      end
      if (done) begin
        dn++;
        if (dcyc < 0) begin
          dcyc = k;
          fit_at_done = fitness;
        end
      end
      if (!gaps && k == 262) begin
        check("login_v1", login, 1);
        check("grid_wren_apply", grid_wren, 0);
      end
      @(posedge clock); #1;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    check("wr_count", wr, 256);
    check("wr_order", bad_wr, 0);
    check("latency", dcyc, exp_lat);
    check("done_count", dn, 1);
    check("fitness", fit_at_done, exp_fit);
    check("fitness_hold", fitness, exp_fit);
    check("busy_after", busy, 0);
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    run_eval(0, 1'b0, 1'b0, 24, 297, 0);
    run_eval(1, 1'b0, 1'b0, 0, 297, 24);
    run_eval(2, 1'b0, 1'b0, 12, 297, 0);
    run_eval(0, 1'b1, 1'b0, 24, 553, 12);
    run_eval(2, 1'b0, 1'b1, 12, 297, 24);
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cfg_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cfg_data = 8'(k);
      @(posedge clock); #1;
    end
    cfg_data = 8'd100;
    @(negedge clock);
    check("load_busy", busy, 1);
    check("load_addr100", ram_address, 100);
    #4 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clock);
    check_reset_vals();
    run_eval(0, 1'b0, 1'b0, 24, 297, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
